// File: rtl/bcd_serial_addsub.sv
// Digit-serial N-digit BCD adder/subtractor, LSD first.
// START/BUSY/DONE handshake with registered results.
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic                  SUB,
  input  logic [4*DIGITS-1:0]   X,
  input  logic [4*DIGITS-1:0]   Y,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [4*DIGITS-1:0]   S,
  output logic                  CARRY,
  output logic                  ERR
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t         state_q;
  logic [W-1:0]   x_q;
  logic [W-1:0]   y_q;
  logic [W-1:0]   res_q;
  logic           sub_q;
  logic           c_q;
  logic [CW-1:0]  idx_q;

  logic [3:0]     y_dig;
  logic [4:0]     t;
  logic [4:0]     t_adj;
  logic [3:0]     dig;
  logic           c_d;
  logic [W+3:0]   res_cat;
  logic [W-1:0]   res_d;
  logic           bad;
  logic           last;

  function automatic logic has_bad(input logic [W-1:0] v);
    logic b;
    b = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) b = 1'b1;
    end
    return b;
  endfunction

  // Subtraction adds the nine's complement with an initial carry of one.
  always_comb begin
    y_dig   = sub_q ? (4'd9 - y_q[3:0]) : y_q[3:0];
    t       = {1'b0, x_q[3:0]} + {1'b0, y_dig} + {4'd0, c_q};
    t_adj   = t - 5'd10;
    dig     = t[3:0];
    c_d     = 1'b0;
    if (t > 5'd9) begin
      dig = t_adj[3:0];
      c_d = 1'b1;
    end
    res_cat = {dig, res_q};
    res_d   = res_cat[W+3:4];
    bad     = has_bad(X) | has_bad(Y);
    last    = (idx_q == CW'(DIGITS - 1));
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      sub_q   <= 1'b0;
      c_q     <= 1'b0;
      idx_q   <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      S       <= '0;
      CARRY   <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            x_q   <= X;
            y_q   <= Y;
            sub_q <= SUB;
            c_q   <= SUB;
            idx_q <= '0;
            res_q <= '0;
            if (bad) begin
              state_q <= FIN;
              DONE    <= 1'b1;
              ERR     <= 1'b1;
              S       <= '0;
              CARRY   <= 1'b0;
            end else begin
              state_q <= RUN;
              BUSY    <= 1'b1;
            end
          end
        end
        RUN: begin
          x_q   <= x_q >> 4;
          y_q   <= y_q >> 4;
          c_q   <= c_d;
          res_q <= res_d;
          idx_q <= idx_q + 1'b1;
          if (last) begin
            state_q <= FIN;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
            S       <= res_d;
            CARRY   <= sub_q ? ~c_d : c_d;
            ERR     <= 1'b0;
          end
        end
        FIN: begin
          DONE    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          BUSY    <= 1'b0;
          DONE    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed bench for bcd_serial_addsub, 4-digit and 1-digit builds.
// Vector table plus handshake, reset and hold sequences.
module tb_bcd_serial_addsub;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;

  logic        start4 = 1'b0;
  logic        sub4 = 1'b0;
  logic [15:0] x4 = '0;
  logic [15:0] y4 = '0;
  logic        busy4, done4, carry4, err4;
  logic [15:0] s4;

  logic        start1 = 1'b0;
  logic        sub1 = 1'b0;
  logic [3:0]  x1 = '0;
  logic [3:0]  y1 = '0;
  logic        busy1, done1, carry1, err1;
  logic [3:0]  s1;

  bit          sel = 1'b0;
  logic        busy_m, done_m, carry_m, err_m;
  logic [15:0] s_m;

  int ncmp = 0;
  int nerr = 0;
  int nvec = 0;

  always #5 CLK = ~CLK;

  bcd_serial_addsub #(.DIGITS(4)) u_dut4 (
    .CLK(CLK), .RST_N(RST_N), .START(start4), .SUB(sub4),
    .X(x4), .Y(y4), .BUSY(busy4), .DONE(done4),
    .S(s4), .CARRY(carry4), .ERR(err4)
  );

  bcd_serial_addsub #(.DIGITS(1)) u_dut1 (
    .CLK(CLK), .RST_N(RST_N), .START(start1), .SUB(sub1),
    .X(x1), .Y(y1), .BUSY(busy1), .DONE(done1),
    .S(s1), .CARRY(carry1), .ERR(err1)
  );

  always_comb begin
    busy_m  = sel ? busy1 : busy4;
    done_m  = sel ? done1 : done4;
    carry_m = sel ? carry1 : carry4;
    err_m   = sel ? err1 : err4;
    s_m     = sel ? {12'd0, s1} : s4;
  end

  typedef struct {
    bit          sel;
    logic [15:0] x;
    logic [15:0] y;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        e;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input string nm);
    int busy_n;
    int done_at;
    int lat;
    nvec++;
    @(negedge CLK);
    sel = v.sel;
    if (v.sel) begin
      x1 = v.x[3:0]; y1 = v.y[3:0]; sub1 = v.sub; start1 = 1'b1;
    end else begin
      x4 = v.x; y4 = v.y; sub4 = v.sub; start4 = 1'b1;
    end
    @(posedge CLK);
    @(negedge CLK);
    start1 = 1'b0;
    start4 = 1'b0;
    x4 = 16'h7777;
    y4 = 16'h3333;
    x1 = 4'h7;
    busy_n  = 0;
    done_at = 0;
    for (int c = 1; c <= 20; c++) begin
      if (busy_m) busy_n++;
      if (done_m) begin
        done_at = c;
        break;
      end
      @(negedge CLK);
    end
    lat = v.e ? 1 : (v.sel ? 2 : 5);
    check({nm, " done_at"}, done_at, lat);
    check({nm, " busy_cycles"}, busy_n, v.e ? 0 : (v.sel ? 1 : 4));
    check({nm, " S"}, {16'd0, s_m}, {16'd0, v.s});
    check({nm, " CARRY"}, {31'd0, carry_m}, {31'd0, v.c});
    check({nm, " ERR"}, {31'd0, err_m}, {31'd0, v.e});
    @(negedge CLK);
    check({nm, " done_pulse"}, {31'd0, done_m}, 32'd0);
  endtask

  vec_t tbl[16];
  int   ntbl;
  int   cnt;

  initial begin
    tbl[0]  = '{0, 16'h0003, 16'h0005, 0, 16'h0008, 0, 0};
    tbl[1]  = '{0, 16'h9999, 16'h0001, 0, 16'h0000, 1, 0};
    tbl[2]  = '{0, 16'h4567, 16'h5433, 0, 16'h0000, 1, 0};
    tbl[3]  = '{0, 16'h0046, 16'h0089, 1, 16'h9957, 1, 0};
    tbl[4]  = '{0, 16'h1000, 16'h0001, 1, 16'h0999, 0, 0};
    tbl[5]  = '{0, 16'h00A1, 16'h0002, 0, 16'h0000, 0, 1};
    tbl[6]  = '{0, 16'h1234, 16'h4321, 0, 16'h5555, 0, 0};
    tbl[7]  = '{0, 16'h0000, 16'h0001, 1, 16'h9999, 1, 0};
    tbl[8]  = '{0, 16'h9999, 16'h9999, 1, 16'h0000, 0, 0};
    tbl[9]  = '{0, 16'h0500, 16'h0500, 0, 16'h1000, 0, 0};
    tbl[10] = '{0, 16'h0012, 16'hF000, 1, 16'h0000, 0, 1};
    tbl[11] = '{1, 16'h0009, 16'h0009, 0, 16'h0008, 1, 0};
    tbl[12] = '{1, 16'h0007, 16'h0006, 0, 16'h0003, 1, 0};
    tbl[13] = '{1, 16'h0003, 16'h0005, 0, 16'h0008, 0, 0};
    tbl[14] = '{1, 16'h0005, 16'h0007, 1, 16'h0008, 1, 0};
    tbl[15] = '{1, 16'h000A, 16'h0001, 0, 16'h0000, 0, 1};
    ntbl = 16;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst BUSY", {31'd0, busy4}, 32'd0);
    check("rst DONE", {31'd0, done4}, 32'd0);
    check("rst S", {16'd0, s4}, 32'd0);
    check("rst CARRY", {31'd0, carry4}, 32'd0);
    check("rst ERR", {31'd0, err4}, 32'd0);
    check("rst S1", {28'd0, s1}, 32'd0);
    RST_N = 1'b1;

    for (int i = 0; i < ntbl; i++) begin
      run_op(tbl[i], $sformatf("vec%0d", i));
    end

    // START re-pulsed while busy must be ignored
    sel = 1'b0;
    nvec++;
    @(negedge CLK);
    x4 = 16'h0003; y4 = 16'h0005; sub4 = 1'b0; start4 = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    start4 = 1'b0;
    @(negedge CLK);
    start4 = 1'b1; x4 = 16'h9999; y4 = 16'h9999; sub4 = 1'b1;
    @(negedge CLK);
    start4 = 1'b0;
    check("repulse BUSY", {31'd0, busy4}, 32'd1);
    @(negedge CLK);
    @(negedge CLK);
    check("repulse DONE", {31'd0, done4}, 32'd1);
    check("repulse S", {16'd0, s4}, 32'h0008);
    check("repulse CARRY", {31'd0, carry4}, 32'd0);
    repeat (3) @(negedge CLK);
    check("hold S", {16'd0, s4}, 32'h0008);
    check("hold DONE", {31'd0, done4}, 32'd0);
    check("hold BUSY", {31'd0, busy4}, 32'd0);

    // Reset during the second RUN cycle aborts the op
    nvec++;
    @(negedge CLK);
    x4 = 16'h1111; y4 = 16'h2222; sub4 = 1'b0; start4 = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    start4 = 1'b0;
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    check("abort BUSY", {31'd0, busy4}, 32'd0);
    check("abort DONE", {31'd0, done4}, 32'd0);
    check("abort S", {16'd0, s4}, 32'd0);
    RST_N = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge CLK);
      if (done4 || busy4) cnt++;
    end
    check("abort no_done", cnt, 0);
    run_op('{0, 16'h2468, 16'h1357, 0, 16'h3825, 0, 0}, "post_rst");

    // START held high is re-accepted after FIN
    nvec++;
    @(negedge CLK);
    x4 = 16'h0001; y4 = 16'h0002; sub4 = 1'b0; start4 = 1'b1;
    @(posedge CLK);
    cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      if (done4) begin
        cnt = c;
        break;
      end
    end
    check("held done_at", cnt, 5);
    check("held S", {16'd0, s4}, 32'h0003);
    @(negedge CLK);
    check("held idle BUSY", {31'd0, busy4}, 32'd0);
    check("held idle DONE", {31'd0, done4}, 32'd0);
    @(negedge CLK);
    check("held reaccept", {31'd0, busy4}, 32'd1);
    start4 = 1'b0;
    x4 = 16'h9999;
    cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      if (done4) begin
        cnt = c;
        break;
      end
    end
    check("held2 done_at", cnt, 4);
    check("held2 S", {16'd0, s4}, 32'h0003);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/bcd_serial_addsub.md
Name: bcd_serial_addsub

Overview:
- Parametrised, digit-serial N-digit BCD adder/subtractor. It processes one BCD digit per clock, least-significant digit first.
- Successor to the single-digit combinational BCD adder, adding multi-digit width, a subtract mode, input-digit validation and a START/BUSY/DONE handshake.
- Sits between operand registers and the display/accumulator logic of the calculator datapath.

Parameters:
- DIGITS, 4, number of BCD digits per operand (>=1); operand width is 4*DIGITS bits.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST_N  input  1  synchronous reset, active-low.
- START  input  1  request; sampled only in IDLE.
- SUB  input  1  0 = X+Y, 1 = X-Y; latched with START.
- X  input  4*DIGITS  operand, packed BCD, digit 0 in [3:0].
- Y  input  4*DIGITS  operand, packed BCD.
- BUSY  output  1  high while digits are being processed.
- DONE  output  1  one-cycle pulse; S/CARRY/ERR valid from this cycle.
- S  output  4*DIGITS  packed BCD result.
- CARRY  output  1  add: decimal carry out of MSD; sub: borrow (1 when X<Y).
- ERR  output  1  1 = some latched input nibble > 9.

Behaviour:
- Reset: when RST_N=0 at an edge, state goes to IDLE, and BUSY, DONE, S, CARRY, ERR all become 0. Reset aborts any operation in flight; no DONE is produced for the aborted operation.
- States:
  - IDLE: BUSY=0, DONE=0.
  - RUN: BUSY=1.
  - FIN: DONE=1 for exactly one cycle, then IDLE.
- IDLE, START=1 at edge k:
  - Latch X, Y and SUB.
  - Check every nibble of X and Y.
  - If any nibble > 9: go to FIN. After edge k, ERR=1, S=0, CARRY=0, DONE=1. BUSY is never asserted.
  - Otherwise: go to RUN with digit index 0 and carry c = SUB.
- RUN, each cycle, digit i:
  - y' = SUB ? (9 - Y_i) : Y_i.
  - t = X_i + y' + c (range 0..19).
  - If t > 9: digit = t - 10, c = 1; else digit = t, c = 0.
  - Store digit i into the internal result and increment i.
  - After DIGITS RUN cycles (edge k+DIGITS), go to FIN.
- FIN: S = result, ERR = 0. CARRY = c for add, CARRY = ~c for sub.
- Subtract result is X-Y mod 10^DIGITS (ten's complement). Example: 0046-0089 gives 9957 with CARRY=1.
- Latency: DONE is high in the cycle following edge k+DIGITS. BUSY is high for exactly DIGITS cycles.
- Output hold: S, CARRY and ERR are registered and change only on entry to FIN or on reset. They hold after DONE until the next accepted operation completes.
- START while BUSY or in FIN: ignored, with no effect on the operation in progress. START held high continuously is re-accepted in the first IDLE cycle after FIN.
- Operand change: X, Y and SUB may change after the START edge without affecting the operation in progress.

Test Plan (DIGITS=4 unless noted):
- Basic add: X=0003, Y=0005, SUB=0, START pulse -> BUSY high 4 cycles, then DONE 1 cycle, S=0008, CARRY=0, ERR=0.
- Ripple carry: X=9999, Y=0001, add -> S=0000, CARRY=1. Then X=4567, Y=5433 -> S=0000, CARRY=1.
- Subtract: X=0046, Y=0089, SUB=1 -> S=9957, CARRY=1. Then X=1000, Y=0001, SUB=1 -> S=0999, CARRY=0.
- Invalid digit: X=00A1, Y=0002 -> DONE in the cycle after START, ERR=1, S=0000, CARRY=0, BUSY never high. A following valid op clears ERR.
- Handshake and reset:
  - START re-pulsed with different operands during BUSY -> ignored; result belongs to the first op.
  - RST_N=0 in the 2nd RUN cycle -> all outputs 0, no DONE, next START works normally.
- DIGITS=1 build: 9+9 -> S=8, CARRY=1. 7+6 -> S=3, CARRY=1. 3+5 -> S=8, CARRY=0. Each DONE arrives 1 cycle after BUSY.
